// File: rtl/add_sub_rr_scheduler_pkg.sv
// Shared types and defaults for the round-robin add/subtract scheduler.
// The scheduler FSM walks IDLE -> EXEC -> RESP for every granted operation.
package add_sub_pkg;

  localparam int WIDTH_DEFAULT   = 8;
  localparam int NUM_REQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/add_sub_rr_scheduler_if.sv
// Request/response bundle between the requesters and the shared add/subtract scheduler.
// Operand buses are flattened; requester i owns slice [i*WIDTH +: WIDTH].
interface add_sub_rr_scheduler_if
  import add_sub_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int WIDTH   = WIDTH_DEFAULT
) ();

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_sub;
  logic [NUM_REQ-1:0]       req_acc;
  logic [NUM_REQ-1:0]       clr_acc;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]         rsp_z;
  logic                     rsp_ovf;
  logic                     rsp_cout;
  logic                     busy;

  modport master (
    output req_valid, req_a, req_b, req_sub, req_acc, clr_acc, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_ovf, rsp_cout, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, req_acc, clr_acc, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_ovf, rsp_cout, busy
  );

endinterface

// File: rtl/add_sub_rr_scheduler_add_sub_unit.sv
// Combinational add/subtract datapath: M = G + (B ^ {sub}) + sub, with carry and signed overflow.
// Kept stand-alone so the board top can reuse it without the scheduler.
module add_sub_unit
  import add_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] m,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] h;
  logic [WIDTH:0]   sum;

  assign h   = b ^ {WIDTH{sub}};
  assign sum = {1'b0, g} + {1'b0, h} + {{WIDTH{1'b0}}, sub};
  assign m    = sum[WIDTH-1:0];
  assign cout = sum[WIDTH];
  // Operands of equal sign producing a result of the other sign is a signed overflow.
  assign ovf  = (g[WIDTH-1] & h[WIDTH-1] & ~m[WIDTH-1]) |
                (~g[WIDTH-1] & ~h[WIDTH-1] & m[WIDTH-1]);

endmodule

// File: rtl/add_sub_rr_scheduler.sv
// Round-robin scheduler sharing one add/subtract unit among NUM_REQ requesters,
// each with a private accumulator for chained "Z +/- B" operations.
module add_sub_rr_scheduler
  import add_sub_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int WIDTH   = WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  add_sub_rr_scheduler_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               sub_reg;
  logic               acc_sel_reg;
  logic [WIDTH-1:0]   acc [NUM_REQ];
  logic [NUM_REQ-1:0] rsp_valid_r;
  logic [WIDTH-1:0]   rsp_z_r;
  logic               rsp_ovf_r;
  logic               rsp_cout_r;

  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   pick_next;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               any_valid;
  logic [WIDTH-1:0]   g_operand;
  logic [WIDTH-1:0]   m;
  logic               cout;
  logic               ovf;

  // First requester with valid set, searching upward from ptr and wrapping at NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [IDX_W-1:0]   ptr);
    int s;
    rr_pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      s = int'(ptr) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      if (valid[s]) rr_pick = IDX_W'(s);
    end
  endfunction

  assign any_valid   = |bus.req_valid;
  assign pick        = rr_pick(bus.req_valid, rr_ptr);
  assign pick_next   = (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
  assign pick_onehot = NUM_REQ'(1) << pick;

  assign bus.req_ready = (rst_n && state == IDLE && any_valid) ? pick_onehot : '0;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_z     = rsp_z_r;
  assign bus.rsp_ovf   = rsp_ovf_r;
  assign bus.rsp_cout  = rsp_cout_r;
  assign bus.busy      = (state != IDLE);

  assign g_operand = acc_sel_reg ? acc[grant_idx] : a_reg;

  add_sub_unit #(.WIDTH(WIDTH)) u_alu (
    .g    (g_operand),
    .b    (b_reg),
    .sub  (sub_reg),
    .m    (m),
    .cout (cout),
    .ovf  (ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      sub_reg     <= 1'b0;
      acc_sel_reg <= 1'b0;
      rsp_valid_r <= '0;
      rsp_z_r     <= '0;
      rsp_ovf_r   <= 1'b0;
      rsp_cout_r  <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) acc[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_idx   <= pick;
            a_reg       <= bus.req_a[int'(pick)*WIDTH +: WIDTH];
            b_reg       <= bus.req_b[int'(pick)*WIDTH +: WIDTH];
            sub_reg     <= bus.req_sub[pick];
            acc_sel_reg <= bus.req_acc[pick];
            rr_ptr      <= pick_next;
            state       <= EXEC;
          end
        end
        EXEC: begin
          rsp_z_r        <= m;
          rsp_ovf_r      <= ovf;
          rsp_cout_r     <= cout;
          acc[grant_idx] <= m;
          rsp_valid_r    <= NUM_REQ'(1) << grant_idx;
          state          <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[grant_idx]) begin
            rsp_valid_r <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Placed last so a clear beats the EXEC write-back to the same accumulator.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.clr_acc[i]) acc[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_add_sub_rr_scheduler.sv
// Directed self-checking bench for add_sub_rr_scheduler: arithmetic, latency, fairness,
// backpressure with accumulator clear, and asynchronous reset in the middle of an operation.
module tb_add_sub_rr_scheduler;

  localparam int NR = 4;
  localparam int W  = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  add_sub_rr_scheduler_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

  add_sub_rr_scheduler #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one operation on requester idx with rsp_ready high and reports the response.
  task automatic run_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic acc,
                        output logic [W-1:0] z, output logic ovf, output logic cout,
                        output int lat, output logic ok);
    int cnt;
    ok  = 1'b1;
    lat = 0;
    z   = '0;
    ovf = 1'b0;
    cout = 1'b0;
    @(negedge clk);
    bus.req_a[idx*W +: W] = a;
    bus.req_b[idx*W +: W] = b;
    bus.req_sub[idx]      = sub;
    bus.req_acc[idx]      = acc;
    bus.req_valid[idx]    = 1'b1;
    bus.rsp_ready         = '1;
    #1;
    cnt = 0;
    while (!bus.req_ready[idx] && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (!bus.req_ready[idx]) begin
      bus.req_valid[idx] = 1'b0;
      ok = 1'b0;
      return;
    end
    @(negedge clk);
    bus.req_valid[idx] = 1'b0;
    lat = 1;
    while (!bus.rsp_valid[idx] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.rsp_valid[idx]) begin
      ok = 1'b0;
      return;
    end
    z    = bus.rsp_z;
    ovf  = bus.rsp_ovf;
    cout = bus.rsp_cout;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_req_ready: got %b expected 0000", bus.req_ready);
    end
    checks++;
    if (bus.rsp_valid !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_rsp_valid: got %b expected 0000", bus.rsp_valid);
    end
    checks++;
    if ({bus.rsp_z, bus.rsp_ovf, bus.rsp_cout, bus.busy} !== 11'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got z=%h ovf=%b cout=%b busy=%b expected all 0",
               bus.rsp_z, bus.rsp_ovf, bus.rsp_cout, bus.busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [W-1:0] z;
    logic ovf, cout, ok;
    int lat;
    run_op(1, 8'h05, 8'h03, 1'b0, 1'b0, z, ovf, cout, lat, ok);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("[TB] FAIL add_handshake: got ok=%b expected 1", ok);
    end
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("[TB] FAIL add_latency: got %0d edges expected 2", lat);
    end
    checks++;
    if ({z, ovf, cout} !== {8'h08, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL add_result: got z=%h ovf=%b cout=%b expected z=08 ovf=0 cout=0", z, ovf, cout);
    end
    // acc[1] + 0 exposes the stored accumulator.
    run_op(1, 8'h00, 8'h00, 1'b0, 1'b1, z, ovf, cout, lat, ok);
    checks++;
    if (z !== 8'h08 || ok !== 1'b1) begin
      failures++;
      $display("[TB] FAIL add_acc1: got z=%h ok=%b expected z=08 ok=1", z, ok);
    end
  endtask

  task automatic test_subtract();
    logic [W-1:0] z;
    logic ovf, cout, ok;
    int lat;
    run_op(0, 8'h10, 8'h20, 1'b1, 1'b0, z, ovf, cout, lat, ok);
    checks++;
    if ({ok, z, ovf, cout} !== {1'b1, 8'hF0, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL sub_result: got ok=%b z=%h ovf=%b cout=%b expected ok=1 z=f0 ovf=0 cout=0",
               ok, z, ovf, cout);
    end
    run_op(0, 8'h00, 8'h10, 1'b0, 1'b1, z, ovf, cout, lat, ok);
    checks++;
    if ({ok, z, ovf, cout} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL sub_chain: got ok=%b z=%h ovf=%b cout=%b expected ok=1 z=00 ovf=0 cout=1",
               ok, z, ovf, cout);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] z;
    logic ovf, cout, ok;
    int lat;
    run_op(2, 8'h7F, 8'h01, 1'b0, 1'b0, z, ovf, cout, lat, ok);
    checks++;
    if ({ok, z, ovf, cout} !== {1'b1, 8'h80, 1'b1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL ovf_add: got ok=%b z=%h ovf=%b cout=%b expected ok=1 z=80 ovf=1 cout=0",
               ok, z, ovf, cout);
    end
    run_op(2, 8'h80, 8'h01, 1'b1, 1'b0, z, ovf, cout, lat, ok);
    checks++;
    if ({ok, z, ovf, cout} !== {1'b1, 8'h7F, 1'b1, 1'b1}) begin
      failures++;
      $display("[TB] FAIL ovf_sub: got ok=%b z=%h ovf=%b cout=%b expected ok=1 z=7f ovf=1 cout=1",
               ok, z, ovf, cout);
    end
  endtask

  task automatic test_backpressure_clear();
    logic [W-1:0] z;
    logic ovf, cout, ok;
    int lat;
    int cnt;
    int bad;
    @(negedge clk);
    bus.req_a[3*W +: W] = 8'h21;
    bus.req_b[3*W +: W] = 8'h12;
    bus.req_sub[3]      = 1'b0;
    bus.req_acc[3]      = 1'b0;
    bus.req_valid[3]    = 1'b1;
    bus.rsp_ready       = 4'b0111;
    #1;
    cnt = 0;
    while (!bus.req_ready[3] && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (bus.req_ready[3] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_grant: got req_ready=%b expected bit 3 set", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid[3] = 1'b0;
    bus.clr_acc[3]   = 1'b1;
    bus.req_valid[0] = 1'b1;
    @(negedge clk);
    bus.clr_acc[3] = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.rsp_valid !== 4'b1000 || bus.rsp_z !== 8'h33 || bus.req_ready !== 4'b0000) bad++;
      if (i < 4) @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL bp_hold: got %0d unstable cycles (last rsp_valid=%b z=%h req_ready=%b) expected 0",
               bad, bus.rsp_valid, bus.rsp_z, bus.req_ready);
    end
    bus.req_valid[0] = 1'b0;
    bus.rsp_ready    = '1;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_release: got rsp_valid=%b busy=%b expected 0000 0", bus.rsp_valid, bus.busy);
    end
    // A cleared acc[3] plus 5 gives 05; a missed clear would give 38.
    run_op(3, 8'h00, 8'h05, 1'b0, 1'b1, z, ovf, cout, lat, ok);
    checks++;
    if (z !== 8'h05 || ok !== 1'b1) begin
      failures++;
      $display("[TB] FAIL clr_acc3: got z=%h ok=%b expected z=05 ok=1", z, ok);
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    int seen;
    @(negedge clk);
    bus.req_a[2*W +: W] = 8'h01;
    bus.req_b[2*W +: W] = 8'h01;
    bus.req_sub[2]      = 1'b0;
    bus.req_acc[2]      = 1'b0;
    bus.req_valid[2]    = 1'b1;
    #1;
    cnt = 0;
    while (!bus.req_ready[2] && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    bus.req_valid[2] = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_exec_busy: got busy=%b expected 1", bus.busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_z, bus.rsp_ovf, bus.rsp_cout, bus.busy} !== 19'h0) begin
      failures++;
      $display("[TB] FAIL mid_reset_outputs: got req_ready=%b rsp_valid=%b z=%h ovf=%b cout=%b busy=%b expected all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_z, bus.rsp_ovf, bus.rsp_cout, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 4'b0000) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("[TB] FAIL mid_no_response: got %0d cycles with rsp_valid expected 0", seen);
    end
    bus.req_valid = '1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL mid_next_grant: got req_ready=%b expected 0001", bus.req_ready);
    end
    bus.req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_fairness();
    int order [5];
    int when [5];
    int n;
    int cyc;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    n   = 0;
    cyc = 0;
    rst_n          = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_sub    = '0;
    bus.req_acc    = '0;
    bus.req_valid  = '1;
    bus.rsp_ready  = '1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL fair_reset_ready: got %b expected 0000", bus.req_ready);
    end
    rst_n = 1'b1;
    #1;
    while (n < 5 && cyc < 60) begin
      if (|(bus.req_ready & bus.req_valid)) begin
        for (int i = 0; i < NR; i++) if (bus.req_ready[i]) order[n] = i;
        when[n] = cyc;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.req_valid = '0;
    checks++;
    if (n !== 5) begin
      failures++;
      $display("[TB] FAIL fair_grant_count: got %0d grants expected 5", n);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (order[k] !== exp_order[k]) begin
        failures++;
        $display("[TB] FAIL fair_order_%0d: got index %0d expected %0d", k, order[k], exp_order[k]);
      end
    end
    for (int k = 1; k < n; k++) begin
      checks++;
      if (when[k] - when[k-1] !== 3) begin
        failures++;
        $display("[TB] FAIL fair_spacing_%0d: got %0d cycles expected 3", k, when[k] - when[k-1]);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = '0;
    bus.req_acc   = '0;
    bus.clr_acc   = '0;
    bus.rsp_ready = '1;
    test_reset();
    test_add();
    test_subtract();
    test_overflow();
    test_backpressure_clear();
    test_reset_mid();
    test_fairness();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
